csr_trap_sequencer: RTL

//  Sequences the multi-CSR updates for machine-mode trap entry and MRET onto the CSR file's three write ports.

---
 rtl/csr_pkg.sv | 30 +++
 rtl/csr_trap_target.sv | 23 ++
 rtl/csr_trap_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, mstatus bit positions, privilege and trap-sequencer state types
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_SAVE,
        ST_T_STATUS,
        ST_T_JUMP,
        ST_R_STATUS,
        ST_R_JUMP
    } trap_seq_state_t;

endpackage

// File: rtl/csr_trap_target.sv
// csr_trap_target: trap redirect PC from mtvec; vectored interrupts only when CSR_TRAP_VECTORED_EN is defined
module csr_trap_target #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mtvec_q,
    input  logic            trap_is_irq,
    input  logic [62:0]     trap_code,
    output logic [XLEN-1:0] target_pc
);

    logic [XLEN-1:0] base;

    assign base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    assign target_pc = (mtvec_q[1:0] == 2'b01 && trap_is_irq) ? base + (XLEN'(trap_code) << 2) : base;
`else
    logic unused_vec;
    assign target_pc  = base;
    assign unused_vec = &{1'b0, mtvec_q[1:0], trap_is_irq, trap_code};
`endif

endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: sequences trap-entry and MRET CSR writes over three ports; optional CSR_TRAP_VECTORED_EN
module csr_trap_sequencer
    import csr_pkg::*;
#(
    parameter int          XLEN       = 64,
    parameter logic [1:0]  PRIV_RESET = 2'b11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_req,
    input  logic            trap_is_irq,
    input  logic [62:0]     trap_code,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mstatus_q,
    input  logic [XLEN-1:0] mtvec_q,
    input  logic [XLEN-1:0] mepc_q,
    output logic            busy,
    output logic            trap_ack,
    output logic            mret_ack,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv_q,
    output logic            wdEn,
    output logic            wdEn2,
    output logic            wdEn3,
    output logic [11:0]     write_target,
    output logic [11:0]     write_target2,
    output logic [11:0]     write_target3,
    output logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] write_data2,
    output logic [XLEN-1:0] write_data3
);

    trap_seq_state_t state_q, state_d;
    logic [1:0]      priv_d;
    logic            busy_q, busy_d;
    logic            trap_ack_q, trap_ack_d;
    logic            mret_ack_q, mret_ack_d;
    logic            redirect_vld_q, redirect_vld_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [2:0]      wd_en_q, wd_en_d;
    logic [11:0]     tgt_q [3];
    logic [11:0]     tgt_d [3];
    logic [XLEN-1:0] dat_q [3];
    logic [XLEN-1:0] dat_d [3];
    logic [XLEN-1:0] trap_status, mret_status, trap_target;

    csr_trap_target #(.XLEN(XLEN)) u_target (
        .mtvec_q     (mtvec_q),
        .trap_is_irq (trap_is_irq),
        .trap_code   (trap_code),
        .target_pc   (trap_target)
    );

    // Decode the current state into next state and the write/ack outputs registered at the next edge
    always_comb begin
        trap_status                                 = mstatus_q;
        trap_status[MSTATUS_MPIE]                   = mstatus_q[MSTATUS_MIE];
        trap_status[MSTATUS_MIE]                    = 1'b0;
        trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = priv_q;
        mret_status                                 = mstatus_q;
        mret_status[MSTATUS_MIE]                    = mstatus_q[MSTATUS_MPIE];
        mret_status[MSTATUS_MPIE]                   = 1'b1;
        mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b00;
        state_d        = state_q;
        priv_d         = priv_q;
        trap_ack_d     = 1'b0;
        mret_ack_d     = 1'b0;
        redirect_vld_d = 1'b0;
        redirect_pc_d  = '0;
        wd_en_d        = '0;
        for (int i = 0; i < 3; i++) begin
            tgt_d[i] = '0;
            dat_d[i] = '0;
        end
        unique case (state_q)
            ST_IDLE: state_d = trap_req ? ST_T_SAVE : mret_req ? ST_R_STATUS : ST_IDLE;
            ST_T_SAVE: begin
                wd_en_d  = 3'b111;
                tgt_d[0] = CSR_MEPC;
                dat_d[0] = trap_pc & ~XLEN'(3);
                tgt_d[1] = CSR_MCAUSE;
                dat_d[1] = XLEN'({trap_is_irq, trap_code});
                tgt_d[2] = CSR_MTVAL;
                dat_d[2] = trap_tval;
                state_d  = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                wd_en_d  = 3'b001;
                tgt_d[0] = CSR_MSTATUS;
                dat_d[0] = trap_status;
                priv_d   = PRIV_M;
                state_d  = ST_T_JUMP;
            end
            ST_T_JUMP: begin
                redirect_vld_d = 1'b1;
                trap_ack_d     = 1'b1;
                redirect_pc_d  = trap_target;
                state_d        = ST_IDLE;
            end
            ST_R_STATUS: begin
                wd_en_d  = 3'b001;
                tgt_d[0] = CSR_MSTATUS;
                dat_d[0] = mret_status;
                priv_d   = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                state_d  = ST_R_JUMP;
            end
            ST_R_JUMP: begin
                redirect_vld_d = 1'b1;
                mret_ack_d     = 1'b1;
                redirect_pc_d  = mepc_q & ~XLEN'(3);
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    // Register state and every output; reset abandons any sequence in flight without an ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            priv_q         <= PRIV_RESET;
            busy_q         <= 1'b0;
            trap_ack_q     <= 1'b0;
            mret_ack_q     <= 1'b0;
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
            wd_en_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            priv_q         <= priv_d;
            busy_q         <= busy_d;
            trap_ack_q     <= trap_ack_d;
            mret_ack_q     <= mret_ack_d;
            redirect_vld_q <= redirect_vld_d;
            redirect_pc_q  <= redirect_pc_d;
            wd_en_q        <= wd_en_d;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i] <= tgt_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign busy          = busy_q;
    assign trap_ack      = trap_ack_q;
    assign mret_ack      = mret_ack_q;
    assign redirect_vld  = redirect_vld_q;
    assign redirect_pc   = redirect_pc_q;
    assign wdEn          = wd_en_q[0];
    assign wdEn2         = wd_en_q[1];
    assign wdEn3         = wd_en_q[2];
    assign write_target  = tgt_q[0];
    assign write_target2 = tgt_q[1];
    assign write_target3 = tgt_q[2];
    assign write_data    = dat_q[0];
    assign write_data2   = dat_q[1];
    assign write_data3   = dat_q[2];

endmodule
